instr_fetch_reg: RTL
====================

Name: instr_fetch_reg

Overview:
- Fetch stage and instruction register that sits directly upstream of the immediate sign-extender and the decoder.
- Owns the PC and issues word reads to instruction memory over a req/ready handshake.
- Latches the returned 32-bit instruction and holds it stable for the extender and decoder until the decoder accepts it.
- Takes branch/jump redirects computed downstream from PC + extended immediate.

Parameters:
- RESET_PC, 64'h0: PC value loaded on reset.
- TIMEOUT, 16: maximum cycles to wait for imem_ready before a fetch error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  64  read address, always equal to pc_out.
- imem_ready  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- ir_out  out  32  latched instruction, feeds the extender's instruction input and the decoder.
- ir_valid  out  1  ir_out holds an instruction not yet consumed.
- pc_out  out  64  PC of the instruction being fetched or held.
- dec_ready  in  1  decoder consumes ir_out this cycle.
- redirect_valid  in  1  take redirect_pc as the next PC.
- redirect_pc  in  64  redirect target.
- fetch_err  out  1  sticky timeout error.

Behaviour:
- States: S_RESET, S_REQ, S_HOLD, S_ERR, encoded 2 bits.
- Reset values, applied asynchronously while reset is low:
  - state = S_RESET, pc_out = RESET_PC, ir_out = 0.
  - ir_valid = 0, imem_req = 0, fetch_err = 0.
  - wait counter = 0, drop flag = 0.
- S_RESET: one cycle after reset deasserts, then go to S_REQ.
- S_REQ:
  - imem_req = 1.
  - Wait counter increments every cycle and clears on entry.
  - On imem_ready with drop = 0: ir_out <= imem_rdata, ir_valid <= 1, go to S_HOLD.
  - Fetch latency is 1 cycle minimum from request to ir_valid (ready in the first S_REQ cycle gives ir_valid on the next edge).
- Redirect during S_REQ:
  - redirect_valid in S_REQ without imem_ready: pc_out <= redirect_pc, drop <= 1, stay in S_REQ.
  - The next imem_ready is discarded and clears drop; the request then continues at the new PC.
  - redirect_valid together with imem_ready in the same cycle: discard the response, pc_out <= redirect_pc, drop stays 0, and the fetch restarts next cycle.
- Timeout: when the counter reaches TIMEOUT - 1 with no imem_ready, fetch_err <= 1, go to S_ERR.
- S_HOLD:
  - imem_req = 0; ir_out and pc_out stay stable.
  - On dec_ready: ir_valid <= 0, pc_out <= redirect_valid ? redirect_pc : pc_out + 4, go to S_REQ.
  - redirect_valid without dec_ready is ignored.
- PC arithmetic: 64-bit, pc + 4 wraps modulo 2^64 with no flag.
- S_ERR:
  - imem_req = 0, ir_valid = 0, fetch_err = 1.
  - Leaves S_ERR only on reset.
- imem_addr is driven combinationally from pc_out.
- Reset asserted mid-request drops the outstanding request. A later imem_ready is ignored because drop is cleared and state is S_RESET.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect whose redirect_pc[1:0] != 2'b00 is not taken: pc_out is unchanged and the state goes to S_ERR.
  - Adds output misalign_err (1 bit, sticky, reset 0), set together with fetch_err.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded.
  - The misalign_err port does not exist.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (S_RESET, S_REQ, S_HOLD, S_ERR).
  - INSTR_W = 32, PC_W = 64, PC_STEP = 4.
  - Opcode constants shared with the extender and decoder (0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 0110111).
- One natural sub-module: fetch_timer, a loadable up-counter with clear and a terminal-count flag, used for the timeout.

Test Plan:
- Reset with RESET_PC = 0, imem_ready 1 cycle after req, rdata = 32'h00500093 (addi) → ir_valid = 1 with ir_out = 32'h00500093, pc_out = 0; on dec_ready, pc_out = 4 and imem_req reasserts the next cycle.
- ir_valid held with dec_ready = 0 for 5 cycles while imem_rdata changes → ir_out stays 32'h00500093 and imem_req stays 0.
- In S_HOLD at pc = 8: dec_ready = 1 with redirect_valid = 1, redirect_pc = 64'h40 → next imem_addr = 64'h40.
- Redirect to 64'h100 two cycles into a pending fetch at pc = 4, then imem_ready with rdata = 32'hDEADBEEF → word discarded, ir_valid stays 0, next accepted word is tagged pc_out = 64'h100.
- imem_ready never asserted → fetch_err = 1 exactly TIMEOUT = 16 cycles after req rises; imem_req = 0 afterwards; only reset clears the error.
- pc = 64'hFFFF_FFFF_FFFF_FFFC, consume → pc_out = 0. With FETCH_MISALIGN_CHECK_EN defined, redirect_pc = 64'h42 → misalign_err = 1, fetch_err = 1, pc_out unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage, the immediate sign-extender
// and the decoder.
//   fetch_state_t : fetch FSM state encoding (2 bits)
//   INSTR_W/PC_W  : instruction and program-counter widths
//   PC_STEP       : sequential PC increment (one 32-bit word)
//   OP_*          : major opcodes shared with the extender and decoder
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  localparam logic [PC_W-1:0] PC_STEP = 64'd4;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Sequential successor; wraps modulo 2^64 with no overflow indication.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Clears the byte-offset bits so a target always names a whole word.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Loadable up-counter with synchronous clear and a terminal-count flag, used
// to bound the wait for an instruction-memory response.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset (count -> 0)
//   clr      in  synchronous clear, highest priority
//   load     in  load load_val
//   load_val in  value loaded when load is high
//   en       in  count up by one
//   tc       out count equals TC_VAL
// -----------------------------------------------------------------------------
module fetch_timer #(
  parameter int           W      = 5,
  parameter logic [W-1:0] TC_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// instr_fetch_reg
// Fetch stage plus instruction register. Owns the PC, reads words from
// instruction memory over a req/ready handshake, and holds the returned word
// stable for the sign-extender and decoder until the decoder takes it.
// Downstream redirects (PC + extended immediate) replace the next PC.
//
// Build option: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect with target[1:0] != 0 is refused, the PC is kept,
//               and the stage stops in S_ERR with misalign_err and fetch_err.
//   undefined : redirect targets are word-aligned by clearing bits [1:0];
//               misalign_err does not exist.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   imem_req       out  read request (high in S_REQ)
//   imem_addr      out  read address, equal to pc_out
//   imem_ready     in   response strobe, imem_rdata valid same cycle
//   imem_rdata     in   instruction word
//   ir_out         out  latched instruction
//   ir_valid       out  ir_out holds an unconsumed instruction
//   pc_out         out  PC of the instruction being fetched or held
//   dec_ready      in   decoder consumes ir_out this cycle
//   redirect_valid in   take redirect_pc as next PC
//   redirect_pc    in   redirect target
//   misalign_err   out  sticky misaligned-redirect error (option only)
//   fetch_err      out  sticky fetch error
// -----------------------------------------------------------------------------
module instr_fetch_reg
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic [PC_W-1:0]    pc_out,
  input  logic               dec_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic               misalign_err,
`endif
  output logic               fetch_err
);

  localparam int               TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT - 1);

  fetch_state_t        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q;
  logic                ir_valid_q;
  logic                drop_q, drop_d;
  logic                fetch_err_q;
  logic                pc_ld, ir_ld, set_valid, clr_valid, err_set;
  logic                tmr_clr, tmr_en, tmr_tc;
  logic                redir_bad;
  logic [PC_W-1:0]     redir_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_bad    = redirect_valid & (|redirect_pc[1:0]);
  assign redir_target = redirect_pc;
`else
  assign redir_bad    = 1'b0;
  assign redir_target = word_align(redirect_pc);
`endif

  fetch_timer #(
    .W      (TMR_W),
    .TC_VAL (TMR_TC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath enables. In S_REQ a redirect outranks both the
  // response and the timeout: the outstanding read belongs to the old PC.
  always_comb begin
    state_d   = state_q;
    pc_ld     = 1'b0;
    pc_d      = pc_q;
    ir_ld     = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    drop_d    = drop_q;
    err_set   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_REQ;
        tmr_clr = 1'b1;
      end

      S_REQ: begin
        tmr_en = 1'b1;
        if (redirect_valid) begin
          tmr_clr = 1'b1;
          if (redir_bad) begin
            state_d = S_ERR;
            err_set = 1'b1;
          end else begin
            pc_ld  = 1'b1;
            pc_d   = redir_target;
            // A response arriving this same cycle is already discarded, so
            // only an unanswered request leaves a stale word in flight.
            drop_d = !imem_ready;
          end
        end else if (imem_ready) begin
          tmr_clr = 1'b1;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            ir_ld     = 1'b1;
            set_valid = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (tmr_tc) begin
          state_d = S_ERR;
          err_set = 1'b1;
        end
      end

      S_HOLD: begin
        if (dec_ready) begin
          clr_valid = 1'b1;
          tmr_clr   = 1'b1;
          if (redirect_valid && redir_bad) begin
            state_d = S_ERR;
            err_set = 1'b1;
          end else begin
            state_d = S_REQ;
            pc_ld   = 1'b1;
            pc_d    = redirect_valid ? redir_target : pc_next(pc_q);
          end
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      if (pc_ld) pc_q <= pc_d;
      if (ir_ld) ir_q <= imem_rdata;
      if (set_valid)      ir_valid_q <= 1'b1;
      else if (clr_valid) ir_valid_q <= 1'b0;
      drop_q <= drop_d;
      if (err_set) fetch_err_q <= 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  // The timeout path only fires without a redirect, so err_set together
  // with redir_bad always means a refused misaligned target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (err_set && redir_bad) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

endmodule
